// File: rtl/control_fsm_pkg.sv
// Shared types for the RV32I multicycle controller: opcodes, FSM states, mux selects.
// CONTROL_FSM_SINGLE_STEP_EN adds the PAUSE state.
package control_fsm_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } rv32i_opcode_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_LOAD_IR  = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_HALT     = 4'd7,
`ifdef CONTROL_FSM_SINGLE_STEP_EN
        S_FLASH    = 4'd8,
        S_PAUSE    = 4'd9
`else
        S_FLASH    = 4'd8
`endif
    } state_t;

    typedef enum logic {
        ADDR_PC  = 1'b0,
        ADDR_ALU = 1'b1
    } addr_sel_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_t;

    // Only the opcodes this datapath can execute; X/unknown falls to default.
    function automatic logic is_supported(logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Controller <-> datapath control bundle; master = controller, slave = datapath.
// CONTROL_FSM_SINGLE_STEP_EN adds step/paused.
interface control_fsm_if #(
    parameter int WIDTH = 32
);
    logic             flash_en;
    logic [6:0]       opcode;
    logic             pc_inc;
    logic             ir_wren;
    logic             regfile_wren;
    logic             mem_wren;
    logic             mem_addr_sel;
    logic             wb_sel;
    logic             halted;
    logic             illegal;
    logic [WIDTH-1:0] instret;
`ifdef CONTROL_FSM_SINGLE_STEP_EN
    logic             step;
    logic             paused;

    modport master (
        input  flash_en, opcode, step,
        output pc_inc, ir_wren, regfile_wren, mem_wren, mem_addr_sel, wb_sel,
               halted, illegal, instret, paused
    );
    modport slave (
        output flash_en, opcode, step,
        input  pc_inc, ir_wren, regfile_wren, mem_wren, mem_addr_sel, wb_sel,
               halted, illegal, instret, paused
    );
`else
    modport master (
        input  flash_en, opcode,
        output pc_inc, ir_wren, regfile_wren, mem_wren, mem_addr_sel, wb_sel,
               halted, illegal, instret
    );
    modport slave (
        output flash_en, opcode,
        input  pc_inc, ir_wren, regfile_wren, mem_wren, mem_addr_sel, wb_sel,
               halted, illegal, instret
    );
`endif
endinterface

// File: rtl/control_fsm_instret_counter.sv
// Retired-instruction counter: wraps silently at 2^WIDTH, sync active-low reset.
module instret_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/control_fsm.sv
// Multicycle Moore controller for the RV32I datapath; yields to the flash loader on flash_en.
// Optional CONTROL_FSM_SINGLE_STEP_EN: park in PAUSE after every retire until step.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    control_fsm_if.master bus
);
`ifdef CONTROL_FSM_SINGLE_STEP_EN
    localparam state_t RETIRE_NEXT = S_PAUSE;
`else
    localparam state_t RETIRE_NEXT = S_FETCH;
`endif

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             retire;
    logic             unsupported;
    logic [WIDTH-1:0] instret;

    logic      pc_inc, ir_wren, regfile_wren, mem_wren, halted;
    addr_sel_t addr_sel;
    wb_sel_t   wb_sel;

    assign unsupported = !is_supported(bus.opcode);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            S_FETCH:   state_d = S_LOAD_IR;
            S_LOAD_IR: state_d = S_DECODE;
            S_DECODE: begin
                if (unsupported) begin
                    illegal_d = 1'b1;
                    if (HALT_ON_ILLEGAL) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = RETIRE_NEXT;
                        retire  = 1'b1;
                    end
                end else if (bus.opcode == OPC_LOAD) begin
                    state_d = S_MEM_ADDR;
                end else if (bus.opcode == OPC_STORE) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC, S_MEM_RD, S_MEM_WR: begin
                state_d = RETIRE_NEXT;
                retire  = 1'b1;
            end
            S_MEM_ADDR: state_d = S_MEM_RD;
            S_HALT:     state_d = S_HALT;
            S_FLASH:    state_d = S_FETCH;
`ifdef CONTROL_FSM_SINGLE_STEP_EN
            S_PAUSE:    if (bus.step) state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
        // Loader takeover aborts whatever is in flight: nothing retires, sticky flag drops.
        if (bus.flash_en) begin
            state_d   = S_FLASH;
            illegal_d = 1'b0;
            retire    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    instret_counter #(.WIDTH(WIDTH)) u_instret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .clr   (1'b0),
        .count (instret)
    );

    always_comb begin
        pc_inc       = 1'b0;
        ir_wren      = 1'b0;
        regfile_wren = 1'b0;
        mem_wren     = 1'b0;
        addr_sel     = ADDR_PC;
        wb_sel       = WB_ALU;
        halted       = 1'b0;
        case (state_q)
            S_LOAD_IR: begin
                ir_wren = 1'b1;
                pc_inc  = 1'b1;
            end
            S_EXEC: regfile_wren = 1'b1;
            S_MEM_ADDR: addr_sel = ADDR_ALU;
            S_MEM_RD: begin
                addr_sel     = ADDR_ALU;
                regfile_wren = 1'b1;
                wb_sel       = WB_MEM;
            end
            S_MEM_WR: begin
                addr_sel = ADDR_ALU;
                mem_wren = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
        // Held in reset: nothing may write or steer the datapath.
        if (!rst) begin
            pc_inc       = 1'b0;
            ir_wren      = 1'b0;
            regfile_wren = 1'b0;
            mem_wren     = 1'b0;
            addr_sel     = ADDR_PC;
            wb_sel       = WB_ALU;
            halted       = 1'b0;
        end
    end

    assign bus.pc_inc       = pc_inc;
    assign bus.ir_wren      = ir_wren;
    assign bus.regfile_wren = regfile_wren;
    assign bus.mem_wren     = mem_wren;
    assign bus.mem_addr_sel = addr_sel;
    assign bus.wb_sel       = wb_sel;
    assign bus.halted       = halted;
    assign bus.illegal      = illegal_q;
    assign bus.instret      = instret;
`ifdef CONTROL_FSM_SINGLE_STEP_EN
    assign bus.paused       = (state_q == S_PAUSE) && rst;
`endif
endmodule
